// File: rtl/hw_stack_unit_if.sv
// Push/pop request and stack status bundle between the register file and hw_stack_unit.
// Peek ports exist only when STACK_PEEK_EN is defined.
interface hw_stack_unit_if #(
    parameter int DATA_W   = 32,
    parameter int AMOUNT_W = 16
);
    // Requests carry no ready: each flag high at a posedge is exactly one operation,
    // always accepted; a rejected push or pop is reported through the sticky flags.
    logic                STACK_push_flag;
    logic [DATA_W-1:0]   STACK_push_value;
    logic                STACK_pop_flag;
    logic [DATA_W-1:0]   STACK_TOP;
    logic [AMOUNT_W-1:0] STACK_AMOUNT;
    logic                STACK_full;
    logic                STACK_empty;
    logic                STACK_overflow;
    logic                STACK_underflow;
`ifdef STACK_PEEK_EN
    logic [AMOUNT_W-1:0] peek_index;
    logic [DATA_W-1:0]   peek_value;
`endif

    modport master (
        output STACK_push_flag, STACK_push_value, STACK_pop_flag,
`ifdef STACK_PEEK_EN
        output peek_index,
        input  peek_value,
`endif
        input  STACK_TOP, STACK_AMOUNT, STACK_full, STACK_empty,
        input  STACK_overflow, STACK_underflow
    );

    modport slave (
        input  STACK_push_flag, STACK_push_value, STACK_pop_flag,
`ifdef STACK_PEEK_EN
        input  peek_index,
        output peek_value,
`endif
        output STACK_TOP, STACK_AMOUNT, STACK_full, STACK_empty,
        output STACK_overflow, STACK_underflow
    );
endinterface

// File: rtl/hw_stack_unit.sv
// LIFO data stack with registered top/count, sticky overflow/underflow flags.
// Optional combinational peek port enabled by defining STACK_PEEK_EN.
module hw_stack_unit #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int AMOUNT_W = 16
) (
    input  logic           clock,
    input  logic           reset,
    hw_stack_unit_if.slave stk
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AMOUNT_W-1:0] DEPTH_A = AMOUNT_W'(DEPTH);

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [AMOUNT_W-1:0] amount_q, amount_d;
    logic [DATA_W-1:0]   top_q, top_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                mem_we;
    logic [PTR_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                is_empty, is_full;
    logic [PTR_W-1:0]    idx_push, idx_top, idx_below;

    assign is_empty  = (amount_q == '0);
    assign is_full   = (amount_q == DEPTH_A);
    // Indices wrap in PTR_W bits; the empty/full guards keep them from being used out of range.
    assign idx_push  = amount_q[PTR_W-1:0];
    assign idx_top   = idx_push - PTR_W'(1);
    assign idx_below = idx_push - PTR_W'(2);

    always_comb begin
        amount_d    = amount_q;
        top_d       = top_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = idx_push;
        mem_wdata   = stk.STACK_push_value;
        case ({stk.STACK_push_flag, stk.STACK_pop_flag})
            2'b10: begin
                if (is_full) begin
                    overflow_d = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    amount_d = amount_q + AMOUNT_W'(1);
                    top_d    = stk.STACK_push_value;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    underflow_d = 1'b1;
                end else if (amount_q == AMOUNT_W'(1)) begin
                    amount_d = '0;
                    top_d    = '0;
                end else begin
                    amount_d = amount_q - AMOUNT_W'(1);
                    top_d    = mem_q[idx_below];
                end
            end
            2'b11: begin
                mem_we = 1'b1;
                top_d  = stk.STACK_push_value;
                if (is_empty) begin
                    amount_d    = AMOUNT_W'(1);
                    underflow_d = 1'b1;
                end else begin
                    mem_waddr = idx_top;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            amount_q    <= '0;
            top_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            amount_q    <= amount_d;
            top_q       <= top_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; TOP and the count gate what is visible.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign stk.STACK_TOP       = top_q;
    assign stk.STACK_AMOUNT    = amount_q;
    assign stk.STACK_full      = is_full;
    assign stk.STACK_empty     = is_empty;
    assign stk.STACK_overflow  = overflow_q;
    assign stk.STACK_underflow = underflow_q;

`ifdef STACK_PEEK_EN
    logic [PTR_W-1:0] peek_addr;
    assign peek_addr      = idx_top - stk.peek_index[PTR_W-1:0];
    assign stk.peek_value = (stk.peek_index < amount_q) ? mem_q[peek_addr] : '0;
`endif
endmodule

// File: tb/tb_hw_stack_unit.sv
// Directed bench for hw_stack_unit; peek test compiled in with STACK_PEEK_EN.
module tb_hw_stack_unit;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 64;
  localparam int AMOUNT_W = 16;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  hw_stack_unit_if #(.DATA_W(DATA_W), .AMOUNT_W(AMOUNT_W)) bus ();

  hw_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AMOUNT_W(AMOUNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .stk   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver: apply one request for one posedge, return at the following negedge
  task automatic step(input logic push, input logic pop, input logic [DATA_W-1:0] val);
    bus.STACK_push_flag  = push;
    bus.STACK_pop_flag   = pop;
    bus.STACK_push_value = val;
    @(posedge clock);
    @(negedge clock);
    bus.STACK_push_flag  = 1'b0;
    bus.STACK_pop_flag   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, '0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 1'b1, '0);        // underflow so reset has something to clear
    step(1'b1, 1'b0, 32'h1);
    step(1'b1, 1'b0, 32'h2);
    reset = 1'b1;
    step(1'b1, 1'b0, 32'h3);
    step(1'b1, 1'b0, 32'h4);
    reset = 1'b0;
    checks++; if (bus.STACK_AMOUNT !== 16'd0) begin errors++; $display("FAIL reset_amount got %0d want 0", bus.STACK_AMOUNT); end
    checks++; if (bus.STACK_TOP !== 32'd0) begin errors++; $display("FAIL reset_top got %h want 0", bus.STACK_TOP); end
    checks++; if (bus.STACK_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.STACK_empty); end
    checks++; if (bus.STACK_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.STACK_full); end
    checks++; if (bus.STACK_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.STACK_overflow); end
    checks++; if (bus.STACK_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", bus.STACK_underflow); end
  endtask

  task automatic test_push_pop();
    logic [DATA_W-1:0] push_v [3];
    logic [DATA_W-1:0] pop_top [3];
    push_v  = '{32'hA, 32'hB, 32'hC};
    pop_top = '{32'hB, 32'hA, 32'h0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, push_v[i]);
      checks++; if (bus.STACK_AMOUNT !== AMOUNT_W'(i + 1)) begin errors++; $display("FAIL push_amount[%0d] got %0d want %0d", i, bus.STACK_AMOUNT, i + 1); end
      checks++; if (bus.STACK_TOP !== push_v[i]) begin errors++; $display("FAIL push_top[%0d] got %h want %h", i, bus.STACK_TOP, push_v[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, '0);
      checks++; if (bus.STACK_AMOUNT !== AMOUNT_W'(2 - i)) begin errors++; $display("FAIL pop_amount[%0d] got %0d want %0d", i, bus.STACK_AMOUNT, 2 - i); end
      checks++; if (bus.STACK_TOP !== pop_top[i]) begin errors++; $display("FAIL pop_top[%0d] got %h want %h", i, bus.STACK_TOP, pop_top[i]); end
    end
    checks++; if (bus.STACK_empty !== 1'b1) begin errors++; $display("FAIL pop_empty got %b want 1", bus.STACK_empty); end
    checks++; if (bus.STACK_underflow !== 1'b0) begin errors++; $display("FAIL pop_no_underflow got %b want 0", bus.STACK_underflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DATA_W'(i));
    checks++; if (bus.STACK_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.STACK_full); end
    checks++; if (bus.STACK_empty !== 1'b0) begin errors++; $display("FAIL fill_empty got %b want 0", bus.STACK_empty); end
    checks++; if (bus.STACK_AMOUNT !== AMOUNT_W'(DEPTH)) begin errors++; $display("FAIL fill_amount got %0d want %0d", bus.STACK_AMOUNT, DEPTH); end
    checks++; if (bus.STACK_TOP !== DATA_W'(DEPTH - 1)) begin errors++; $display("FAIL fill_top got %h want %h", bus.STACK_TOP, DEPTH - 1); end
    checks++; if (bus.STACK_overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow got %b want 0", bus.STACK_overflow); end
    step(1'b1, 1'b0, 32'hDEAD);
    checks++; if (bus.STACK_AMOUNT !== AMOUNT_W'(DEPTH)) begin errors++; $display("FAIL ovf_amount got %0d want %0d", bus.STACK_AMOUNT, DEPTH); end
    checks++; if (bus.STACK_TOP !== DATA_W'(DEPTH - 1)) begin errors++; $display("FAIL ovf_top got %h want %h", bus.STACK_TOP, DEPTH - 1); end
    checks++; if (bus.STACK_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.STACK_overflow); end
    step(1'b1, 1'b1, 32'h99);    // replace-top while full is legal
    checks++; if (bus.STACK_TOP !== 32'h99) begin errors++; $display("FAIL full_replace_top got %h want 99", bus.STACK_TOP); end
    checks++; if (bus.STACK_AMOUNT !== AMOUNT_W'(DEPTH)) begin errors++; $display("FAIL full_replace_amount got %0d want %0d", bus.STACK_AMOUNT, DEPTH); end
    step(1'b0, 1'b1, '0);
    checks++; if (bus.STACK_TOP !== DATA_W'(DEPTH - 2)) begin errors++; $display("FAIL full_pop_top got %h want %h", bus.STACK_TOP, DEPTH - 2); end
    checks++; if (bus.STACK_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.STACK_overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b0, 32'h11);
    step(1'b1, 1'b0, 32'h22);
    step(1'b1, 1'b1, 32'h55);
    checks++; if (bus.STACK_AMOUNT !== 16'd2) begin errors++; $display("FAIL replace_amount got %0d want 2", bus.STACK_AMOUNT); end
    checks++; if (bus.STACK_TOP !== 32'h55) begin errors++; $display("FAIL replace_top got %h want 55", bus.STACK_TOP); end
    step(1'b0, 1'b1, '0);
    checks++; if (bus.STACK_TOP !== 32'h11) begin errors++; $display("FAIL replace_pop_top got %h want 11", bus.STACK_TOP); end
    checks++; if (bus.STACK_AMOUNT !== 16'd1) begin errors++; $display("FAIL replace_pop_amount got %0d want 1", bus.STACK_AMOUNT); end
    checks++; if ({bus.STACK_overflow, bus.STACK_underflow} !== 2'b00) begin errors++; $display("FAIL replace_flags got %b want 00", {bus.STACK_overflow, bus.STACK_underflow}); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, '0);        // AMOUNT 1 -> 0
    checks++; if (bus.STACK_TOP !== 32'h0) begin errors++; $display("FAIL last_pop_top got %h want 0", bus.STACK_TOP); end
    step(1'b0, 1'b1, '0);
    checks++; if (bus.STACK_underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got %b want 1", bus.STACK_underflow); end
    checks++; if (bus.STACK_AMOUNT !== 16'd0) begin errors++; $display("FAIL udf_amount got %0d want 0", bus.STACK_AMOUNT); end
    checks++; if (bus.STACK_TOP !== 32'h0) begin errors++; $display("FAIL udf_top got %h want 0", bus.STACK_TOP); end
    do_reset();
    step(1'b1, 1'b1, 32'h7);
    checks++; if (bus.STACK_AMOUNT !== 16'd1) begin errors++; $display("FAIL empty_pp_amount got %0d want 1", bus.STACK_AMOUNT); end
    checks++; if (bus.STACK_TOP !== 32'h7) begin errors++; $display("FAIL empty_pp_top got %h want 7", bus.STACK_TOP); end
    checks++; if (bus.STACK_underflow !== 1'b1) begin errors++; $display("FAIL empty_pp_underflow got %b want 1", bus.STACK_underflow); end
    step(1'b0, 1'b0, '0);
    checks++; if (bus.STACK_underflow !== 1'b1) begin errors++; $display("FAIL udf_sticky got %b want 1", bus.STACK_underflow); end
  endtask

`ifdef STACK_PEEK_EN
  task automatic test_peek();
    logic [DATA_W-1:0] exp_peek [4];
    exp_peek = '{32'h3, 32'h2, 32'h1, 32'h0};
    do_reset();
    step(1'b1, 1'b0, 32'h1);
    step(1'b1, 1'b0, 32'h2);
    step(1'b1, 1'b0, 32'h3);
    for (int i = 0; i < 4; i++) begin
      bus.peek_index = AMOUNT_W'(i);
      #1;
      checks++; if (bus.peek_value !== exp_peek[i]) begin errors++; $display("FAIL peek[%0d] got %h want %h", i, bus.peek_value, exp_peek[i]); end
    end
    bus.peek_index = '0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.STACK_push_flag  = 1'b0;
    bus.STACK_pop_flag   = 1'b0;
    bus.STACK_push_value = '0;
`ifdef STACK_PEEK_EN
    bus.peek_index = '0;
`endif
    @(negedge clock);
    test_reset();
    test_push_pop();
    test_overflow();
    test_back_to_back();
    test_underflow();
`ifdef STACK_PEEK_EN
    test_peek();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
